// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: accepts a parallel word, walks START/DATA/PARITY/STOP
// and feeds the select, serial-bit and parity inputs of the downstream TX mux.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_p_data,
    input  logic                  i_data_valid,
    input  logic                  i_par_en,
    input  logic                  i_par_typ,
    output logic [SEL_WIDTH-1:0]  o_mux_sel,
    output logic                  o_ser_data,
    output logic                  o_parity_bit,
    output logic                  o_busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    // The state code doubles as the mux select, so the encoding is fixed.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_START  = 3'b001,
        ST_DATA   = 3'b010,
        ST_PARITY = 3'b011,
        ST_STOP   = 3'b100
    } state_e;

    state_e                  state_r;
    state_e                  state_nxt_s;
    logic [DATA_WIDTH-1:0]   shift_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    par_en_r;
    logic                    parity_r;
    logic                    accept_s;
    logic                    last_bit_s;

    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data,
                                         input logic odd);
        return (^data) ^ odd;
    endfunction

    // Accept decode and last-data-bit detection.
    always_comb begin
        accept_s   = 1'b0;
        last_bit_s = 1'b0;
        if (state_r == ST_IDLE) begin
            accept_s = i_data_valid;
        end else begin
            accept_s = 1'b0;
        end
        if (state_r == ST_DATA) begin
            last_bit_s = (cnt_r == LAST_CNT);
        end else begin
            last_bit_s = 1'b0;
        end
    end

    // Next-state logic; unused codes fall back to IDLE.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START:  state_nxt_s = ST_DATA;
            ST_DATA: begin
                if (!last_bit_s) begin
                    state_nxt_s = ST_DATA;
                end else if (par_en_r) begin
                    state_nxt_s = ST_PARITY;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            ST_PARITY: state_nxt_s = ST_STOP;
            ST_STOP:   state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // State, payload shifter, bit counter and latched frame configuration.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r  <= ST_IDLE;
            shift_r  <= {DATA_WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            par_en_r <= 1'b0;
            parity_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        shift_r  <= i_p_data;
                        par_en_r <= i_par_en;
                        parity_r <= calc_parity(i_p_data, i_par_typ);
                    end
                end
                ST_START: cnt_r <= {CNT_W{1'b0}};
                ST_DATA: begin
                    shift_r <= {1'b0, shift_r[DATA_WIDTH-1:1]};
                    cnt_r   <= cnt_r + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded only from registered state.
    assign o_mux_sel    = SEL_WIDTH'(state_r);
    assign o_ser_data   = (state_r == ST_DATA) ? shift_r[0] : 1'b0;
    assign o_parity_bit = parity_r;
    assign o_busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed table, hand sequences and random
// traffic, all compared against a per-cycle frame queue built from the frame rules.
module tb_uart_tx_ctrl;

    localparam int DW = 8;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [DW-1:0] i_p_data;
    logic          i_data_valid;
    logic          i_par_en;
    logic          i_par_typ;
    logic [2:0]    o_mux_sel;
    logic          o_ser_data;
    logic          o_parity_bit;
    logic          o_busy;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    uart_tx_ctrl #(.DATA_WIDTH(DW), .SEL_WIDTH(3)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_p_data(i_p_data),
        .i_data_valid(i_data_valid), .i_par_en(i_par_en), .i_par_typ(i_par_typ),
        .o_mux_sel(o_mux_sel), .o_ser_data(o_ser_data),
        .o_parity_bit(o_parity_bit), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: the phase visible now, plus the queue of phases still to come.
    typedef struct packed { logic [2:0] sel; logic ser; } ph_t;
    ph_t  q[$];
    ph_t  cur;
    logic exp_par;

    function automatic ph_t mk(input logic [2:0] sel, input logic ser);
        ph_t p;
        p.sel = sel;
        p.ser = ser;
        return p;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cycle, act, exp);
        end
    endtask

    // Drive one bit period, advance the model, and compare all outputs after the edge.
    task automatic step(input logic rst, input logic valid, input logic [DW-1:0] data,
                        input logic pe, input logic pt);
        i_rst        = rst;
        i_data_valid = valid;
        i_p_data     = data;
        i_par_en     = pe;
        i_par_typ    = pt;
        if (rst) begin
            q.delete();
            cur     = mk(3'd0, 1'b0);
            exp_par = 1'b0;
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else if (cur.sel == 3'd0 && valid) begin
            exp_par = 1'($countones(data) % 2) ^ pt;
            cur = mk(3'd1, 1'b0);
            for (int k = 0; k < DW; k++) q.push_back(mk(3'd2, data[k]));
            if (pe) q.push_back(mk(3'd3, 1'b0));
            q.push_back(mk(3'd4, 1'b0));
        end else begin
            cur = mk(3'd0, 1'b0);
        end
        @(posedge i_clk);
        @(negedge i_clk);
        cycle++;
        check("mux_sel", 8'(o_mux_sel), 8'(cur.sel));
        check("ser_data", 8'(o_ser_data), 8'(cur.ser));
        check("busy", 8'(o_busy), 8'(cur.sel != 3'd0));
        check("parity_bit", 8'(o_parity_bit), 8'(exp_par));
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Send one frame and count busy cycles until the controller is idle again.
    task automatic frame(input logic [DW-1:0] data, input logic pe, input logic pt,
                         output int busy_cycles);
        busy_cycles = 0;
        step(1'b0, 1'b1, data, pe, pt);
        for (int n = 0; n < 20 && o_busy; n++) begin
            busy_cycles++;
            idle_step();
        end
    endtask

    typedef struct {
        logic          valid;
        logic [DW-1:0] data;
        logic          pe, pt;
        logic [2:0]    sel;
        logic          ser, busy, par;
    } vec_t;

    vec_t          tbl[12];
    logic [DW-1:0] pat;
    int            bc;

    initial begin
        pat = 8'hA5;
        tbl[0] = '{valid:1'b1, data:8'hA5, pe:1'b1, pt:1'b0, sel:3'd1, ser:1'b0, busy:1'b1, par:1'b0};
        for (int i = 1; i <= DW; i++)
            tbl[i] = '{valid:1'b0, data:8'h3C, pe:1'b0, pt:1'b1, sel:3'd2, ser:pat[i-1], busy:1'b1, par:1'b0};
        tbl[9]  = '{valid:1'b0, data:8'h00, pe:1'b0, pt:1'b0, sel:3'd3, ser:1'b0, busy:1'b1, par:1'b0};
        tbl[10] = '{valid:1'b0, data:8'h00, pe:1'b0, pt:1'b0, sel:3'd4, ser:1'b0, busy:1'b1, par:1'b0};
        tbl[11] = '{valid:1'b0, data:8'h00, pe:1'b0, pt:1'b0, sel:3'd0, ser:1'b0, busy:1'b0, par:1'b0};

        cur = mk(3'd0, 1'b0);
        exp_par = 1'b0;
        @(negedge i_clk);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1);
        check("reset_sel", 8'(o_mux_sel), 8'h00);
        idle_step();

        // Even parity frame from the directed table.
        for (int i = 0; i < 12; i++) begin
            step(1'b0, tbl[i].valid, tbl[i].data, tbl[i].pe, tbl[i].pt);
            check("tbl_sel", 8'(o_mux_sel), 8'(tbl[i].sel));
            check("tbl_ser", 8'(o_ser_data), 8'(tbl[i].ser));
            check("tbl_busy", 8'(o_busy), 8'(tbl[i].busy));
            check("tbl_par", 8'(o_parity_bit), 8'(tbl[i].par));
        end

        frame(8'hA5, 1'b1, 1'b1, bc);
        check("odd_a5_parity", 8'(o_parity_bit), 8'h01);
        check("odd_a5_len", 8'(bc), 8'd11);
        frame(8'h01, 1'b1, 1'b0, bc);
        check("even_01_parity", 8'(o_parity_bit), 8'h01);
        frame(8'h3C, 1'b0, 1'b0, bc);
        check("nopar_len", 8'(bc), 8'd10);

        // Valid pulses with 0xFF during DATA must be ignored.
        step(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
        idle_step();
        idle_step();
        step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
        for (int n = 0; n < 20 && o_busy; n++) idle_step();
        idle_step();
        check("ignore_idle", 8'(o_mux_sel), 8'h00);

        // Reset asserted during the 4th DATA cycle.
        step(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
        for (int n = 0; n < 4; n++) idle_step();
        check("pre_reset_data", 8'(o_mux_sel), 8'h02);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("midreset_sel", 8'(o_mux_sel), 8'h00);
        frame(8'h5A, 1'b1, 1'b0, bc);
        check("post_reset_len", 8'(bc), 8'd11);

        // Back-to-back with valid held: one IDLE cycle between STOP and next START.
        step(1'b0, 1'b1, 8'h81, 1'b1, 1'b0);
        for (int n = 0; n < 12; n++) begin
            step(1'b0, 1'b1, 8'h7E, 1'b1, 1'b0);
            if (n == 9)  check("b2b_stop", 8'(o_mux_sel), 8'h04);
            if (n == 10) check("b2b_gap", 8'(o_mux_sel), 8'h00);
            if (n == 11) check("b2b_start", 8'(o_mux_sel), 8'h01);
        end
        for (int n = 0; n < 20 && o_busy; n++) idle_step();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 800; n++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
                 DW'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
